data_memory_sized: RTL and testbench

- Successor to the single-port data memory.
- Adds byte/half/word/dword sized accesses within a word, with zero- or sign-extension on reads and byte-merge on writes.
- Adds misalignment error detection and a valid/ready request interface.
- Adds a hardware clear sequence after reset and a selectable debug read port. Sits between the execute stage and data storage.

---
 rtl/data_mem_pkg.sv | 35 +++
 rtl/mem_lane_align.sv | 86 ++++++++
 rtl/data_memory_sized.sv | 163 ++++++++++++++++
 tb/tb_data_memory_sized.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_pkg
// Shared encodings for the sized data memory:
//   size_e  : access size field of a request (byte/half/word32/dword64)
//   state_e : controller states (hardware clear, idle/serving)
//   size_bytes() : number of bytes covered by an access of a given size
// -----------------------------------------------------------------------------
package data_mem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE  = 2'd0,
      SZ_HALF  = 2'd1,
      SZ_WORD  = 2'd2,
      SZ_DWORD = 2'd3
   } size_e;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_e;

   // Bytes touched by an access of the given size encoding.
   function automatic int size_bytes(input logic [1:0] size);
      int n_bytes;
      case (size)
         SZ_BYTE:  n_bytes = 32'sd1;
         SZ_HALF:  n_bytes = 32'sd2;
         SZ_WORD:  n_bytes = 32'sd4;
         SZ_DWORD: n_bytes = 32'sd8;
         default:  n_bytes = 32'sd1;
      endcase
      return n_bytes;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Purely combinational lane logic for one memory word.
// Ports:
//   word         in  current word contents
//   offset       in  byte offset of the access inside the word
//   size         in  access size encoding (see data_mem_pkg::size_e)
//   sign_ext     in  1 = sign-extend the read lane, 0 = zero-extend
//   wdata        in  store data, low n bytes used
//   rdata_ext    out selected lane extended to the word width (0 on error)
//   wdata_merged out word with the lane replaced by store data (word on error)
//   err          out misaligned access or access wider than the word
// -----------------------------------------------------------------------------
module mem_lane_align
   import data_mem_pkg::*;
#(
   parameter int WORD_SIZE = 64,
   parameter int OFS_W     = $clog2(WORD_SIZE / 8)
) (
   input  logic [WORD_SIZE-1:0] word,
   input  logic [OFS_W-1:0]     offset,
   input  logic [1:0]           size,
   input  logic                 sign_ext,
   input  logic [WORD_SIZE-1:0] wdata,
   output logic [WORD_SIZE-1:0] rdata_ext,
   output logic [WORD_SIZE-1:0] wdata_merged,
   output logic                 err
);

   localparam int NB = WORD_SIZE / 8;

   int                   n_bytes_s;
   int                   lane_bits_s;
   int                   ofs_int_s;
   logic                 oversize_s;
   logic                 misalign_s;
   logic                 sign_bit_s;
   logic [WORD_SIZE-1:0] shifted_s;
   logic [WORD_SIZE-1:0] wshift_s;

   // Lane extraction with extension, byte-merge for stores, and error decode.
   always_comb begin
      n_bytes_s    = size_bytes(size);
      lane_bits_s  = n_bytes_s * 32'sd8;
      ofs_int_s    = int'(offset);
      oversize_s   = (lane_bits_s > WORD_SIZE);
      misalign_s   = ((ofs_int_s % n_bytes_s) != 32'sd0);
      err          = oversize_s || misalign_s;
      // Move the addressed lane down to bit 0 / store data up to the lane.
      shifted_s    = word >> {offset, 3'b000};
      wshift_s     = wdata << {offset, 3'b000};
      sign_bit_s   = 1'b0;
      rdata_ext    = '0;
      wdata_merged = word;

      // Pick the lane MSB with a loop to keep the index within the vector.
      for (int i = 0; i < WORD_SIZE; i++) begin
         if (i == lane_bits_s - 1) begin
            sign_bit_s = shifted_s[i];
         end else begin
            sign_bit_s = sign_bit_s;
         end
      end

      if (err) begin
         rdata_ext    = '0;
         wdata_merged = word;
      end else begin
         for (int i = 0; i < WORD_SIZE; i++) begin
            if (i < lane_bits_s) begin
               rdata_ext[i] = shifted_s[i];
            end else begin
               rdata_ext[i] = sign_ext & sign_bit_s;
            end
         end
         for (int b = 0; b < NB; b++) begin
            if ((b >= ofs_int_s) && (b < ofs_int_s + n_bytes_s)) begin
               wdata_merged[b*8 +: 8] = wshift_s[b*8 +: 8];
            end else begin
               wdata_merged[b*8 +: 8] = word[b*8 +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/data_memory_sized.sv
// -----------------------------------------------------------------------------
// data_memory_sized
// Single-port word memory with byte/half/word/dword sized accesses, sign or
// zero extension on loads, byte-merge on stores, misalignment detection, a
// valid/ready request interface and a hardware clear sequence after reset.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   req_valid/ready request handshake (accept = valid && ready)
//   req_write       1 = store, 0 = load
//   req_addr        byte address {word index, byte offset}
//   req_size        0 byte, 1 half, 2 word32, 3 dword64
//   req_signed      loads: 1 = sign-extend, 0 = zero-extend
//   req_wdata       store data (low n bytes used)
//   resp_valid      one-cycle response pulse, cycle after accept
//   resp_rdata      prior lane contents, extended (0 on error)
//   resp_err        misaligned or oversize access
//   dbg_addr/data   combinational debug read of a whole word
//   busy            clear sequence in progress
// -----------------------------------------------------------------------------
module data_memory_sized
   import data_mem_pkg::*;
#(
   parameter int WORD_SIZE      = 64,
   parameter int DATA_ADDR_SIZE = 8,
   parameter int OFS_W          = $clog2(WORD_SIZE / 8)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            req_valid,
   output logic                            req_ready,
   input  logic                            req_write,
   input  logic [DATA_ADDR_SIZE+OFS_W-1:0] req_addr,
   input  logic [1:0]                      req_size,
   input  logic                            req_signed,
   input  logic [WORD_SIZE-1:0]            req_wdata,
   output logic                            resp_valid,
   output logic [WORD_SIZE-1:0]            resp_rdata,
   output logic                            resp_err,
   input  logic [DATA_ADDR_SIZE-1:0]       dbg_addr,
   output logic [WORD_SIZE-1:0]            dbg_data,
   output logic                            busy
);

   localparam int DEPTH = 1 << DATA_ADDR_SIZE;

   logic [WORD_SIZE-1:0]      mem_r [0:DEPTH-1];
   state_e                    state_r;
   state_e                    state_next_s;
   logic [DATA_ADDR_SIZE-1:0] clr_ptr_r;

   logic [DATA_ADDR_SIZE-1:0] word_idx_s;
   logic [OFS_W-1:0]          offset_s;
   logic [WORD_SIZE-1:0]      cur_word_s;
   logic [WORD_SIZE-1:0]      lane_rdata_s;
   logic [WORD_SIZE-1:0]      merged_s;
   logic                      lane_err_s;
   logic                      accept_s;

   logic                      wr_en_s;
   logic [DATA_ADDR_SIZE-1:0] wr_idx_s;
   logic [WORD_SIZE-1:0]      wr_data_s;

   assign word_idx_s = req_addr[DATA_ADDR_SIZE+OFS_W-1:OFS_W];
   assign offset_s   = req_addr[OFS_W-1:0];
   assign cur_word_s = mem_r[word_idx_s];
   assign dbg_data   = mem_r[dbg_addr];

   // Reset has priority: the handshake is closed while rst is high.
   assign req_ready  = (state_r == ST_IDLE) && !rst;
   assign busy       = (state_r == ST_CLEAR) || rst;
   assign accept_s   = req_valid && req_ready;

   mem_lane_align #(
      .WORD_SIZE (WORD_SIZE),
      .OFS_W     (OFS_W)
   ) u_lane (
      .word         (cur_word_s),
      .offset       (offset_s),
      .size         (req_size),
      .sign_ext     (req_signed),
      .wdata        (req_wdata),
      .rdata_ext    (lane_rdata_s),
      .wdata_merged (merged_s),
      .err          (lane_err_s)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_CLEAR;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state: leave CLEAR once the last entry has been written.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_CLEAR: begin
            if (clr_ptr_r == {DATA_ADDR_SIZE{1'b1}}) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_CLEAR;
            end
         end
         ST_IDLE:  state_next_s = ST_IDLE;
         default:  state_next_s = ST_CLEAR;
      endcase
   end

   // Clear pointer walks every entry once per clear sequence.
   always_ff @(posedge clk) begin
      if (rst) begin
         clr_ptr_r <= '0;
      end else if (state_r == ST_CLEAR) begin
         clr_ptr_r <= clr_ptr_r + {{(DATA_ADDR_SIZE-1){1'b0}}, 1'b1};
      end
   end

   // Single write port shared by the clear sequence and accepted stores.
   always_comb begin
      wr_en_s   = 1'b0;
      wr_idx_s  = word_idx_s;
      wr_data_s = merged_s;
      if (rst) begin
         wr_en_s = 1'b0;
      end else if (state_r == ST_CLEAR) begin
         wr_en_s   = 1'b1;
         wr_idx_s  = clr_ptr_r;
         wr_data_s = '0;
      end else if (accept_s && req_write && !lane_err_s) begin
         wr_en_s = 1'b1;
      end else begin
         wr_en_s = 1'b0;
      end
   end

   // Storage array write; contents are not reset, the clear sequence zeroes them.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[wr_idx_s] <= wr_data_s;
      end
   end

   // Response registers: lane value sampled before this cycle's write lands.
   always_ff @(posedge clk) begin
      if (rst) begin
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else if (accept_s) begin
         resp_valid <= 1'b1;
         resp_rdata <= lane_rdata_s;
         resp_err   <= lane_err_s;
      end else begin
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_data_memory_sized.sv
// -----------------------------------------------------------------------------
// tb_data_memory_sized
// Directed bench for data_memory_sized with default parameters. A byte-level
// reference model produces the expected response of each request; expected
// responses are queued when a request is driven and compared one cycle later.
// -----------------------------------------------------------------------------
module tb_data_memory_sized;

   typedef struct packed {
      logic        valid;
      logic [63:0] rdata;
      logic        err;
   } resp_t;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [10:0] req_addr;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [63:0] req_wdata;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        resp_err;
   logic [7:0]  dbg_addr;
   logic [63:0] dbg_data;
   logic        busy;

   int          checks = 0;
   int          errors = 0;
   resp_t       exp_q[$];
   logic [7:0]  model_mem [0:2047];

   data_memory_sized dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .dbg_addr   (dbg_addr),
      .dbg_data   (dbg_data),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 2048; i++) model_mem[i] = 8'h00;
   endtask

   // Reference behaviour of one accepted request, updating the byte model.
   task automatic model_req(input logic w, input logic [10:0] addr, input logic [1:0] size,
                            input logic sgn, input logic [63:0] wdata, output resp_t r);
      int          n;
      int          off;
      int          base;
      logic [63:0] lane;
      n    = 1 << size;
      off  = int'(addr[2:0]);
      base = int'(addr[10:3]) * 8;
      lane = 64'h0;
      if ((off % n) != 0 || n * 8 > 64) begin
         r = '{valid: 1'b1, rdata: 64'h0, err: 1'b1};
      end else begin
         for (int b = 0; b < n; b++) lane[b*8 +: 8] = model_mem[base + off + b];
         if (sgn && lane[n*8-1]) begin
            for (int b = n; b < 8; b++) lane[b*8 +: 8] = 8'hFF;
         end
         r = '{valid: 1'b1, rdata: lane, err: 1'b0};
         if (w) begin
            for (int b = 0; b < n; b++) model_mem[base + off + b] = wdata[b*8 +: 8];
         end
      end
   endtask

   function automatic logic [63:0] model_word(input int idx);
      logic [63:0] wv;
      for (int b = 0; b < 8; b++) wv[b*8 +: 8] = model_mem[idx*8 + b];
      return wv;
   endfunction

   task automatic check_resp(input string tag);
      resp_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: observed empty scoreboard expected an entry", tag);
      end else begin
         e = exp_q.pop_front();
         chk({tag, ".valid"}, {63'h0, resp_valid}, {63'h0, e.valid});
         chk({tag, ".rdata"}, resp_rdata, e.rdata);
         chk({tag, ".err"},   {63'h0, resp_err},   {63'h0, e.err});
      end
   endtask

   // One request cycle: drive, push expectation, compare the response.
   task automatic do_req(input string tag, input logic w, input logic [10:0] addr,
                         input logic [1:0] size, input logic sgn, input logic [63:0] wdata);
      resp_t e;
      model_req(w, addr, size, sgn, wdata, e);
      exp_q.push_back(e);
      req_valid  = 1'b1;
      req_write  = w;
      req_addr   = addr;
      req_size   = size;
      req_signed = sgn;
      req_wdata  = wdata;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      check_resp(tag);
   endtask

   task automatic do_idle(input string tag);
      exp_q.push_back('{valid: 1'b0, rdata: 64'h0, err: 1'b0});
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      check_resp(tag);
   endtask

   task automatic wait_clear(input string tag);
      int cnt;
      cnt = 0;
      while (busy && cnt < 1000) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      chk({tag, ".len"},   64'(cnt), 64'd256);
      chk({tag, ".ready"}, {63'h0, req_ready}, 64'd1);
      chk({tag, ".busy"},  {63'h0, busy}, 64'd0);
   endtask

   task automatic dbg_chk(input string tag, input logic [7:0] idx, input logic [63:0] exp);
      dbg_addr = idx;
      #1;
      chk(tag, dbg_data, exp);
   endtask

   initial begin
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_addr   = 11'h000;
      req_size   = 2'd0;
      req_signed = 1'b0;
      req_wdata  = 64'h0;
      dbg_addr   = 8'd0;
      model_clear();

      // 1. Reset and clear sequence
      repeat (3) @(posedge clk);
      #1;
      chk("rst.busy",  {63'h0, busy}, 64'd1);
      chk("rst.ready", {63'h0, req_ready}, 64'd0);
      chk("rst.valid", {63'h0, resp_valid}, 64'd0);
      chk("rst.rdata", resp_rdata, 64'h0);
      chk("rst.err",   {63'h0, resp_err}, 64'd0);
      rst = 1'b0;
      wait_clear("clear1");
      dbg_chk("clear1.dbg255", 8'd255, 64'h0);
      dbg_chk("clear1.dbg0",   8'd0,   64'h0);

      // 2. Dword store then byte loads
      do_req("dw_store",  1'b1, 11'h010, 2'd3, 1'b0, 64'h8877665544332211);
      do_req("ld_b_sgn",  1'b0, 11'h017, 2'd0, 1'b1, 64'h0);
      chk("ld_b_sgn.const", model_word(2), 64'h8877665544332211);
      do_req("ld_b_uns",  1'b0, 11'h017, 2'd0, 1'b0, 64'h0);
      do_idle("idle1");

      // 3. Half store merge
      do_req("h_store",   1'b1, 11'h012, 2'd1, 1'b0, 64'h000000000000BEEF);
      dbg_chk("h_store.dbg", 8'd2, 64'h88776655BEEF2211);
      do_req("ld_w_sgn",  1'b0, 11'h014, 2'd2, 1'b1, 64'h0);
      do_req("ld_w_uns",  1'b0, 11'h014, 2'd2, 1'b0, 64'h0);
      do_req("ld_h_sgn",  1'b0, 11'h012, 2'd1, 1'b1, 64'h0);

      // 4. Misaligned accesses
      do_req("mis_store", 1'b1, 11'h013, 2'd2, 1'b0, 64'hDEADBEEFCAFEF00D);
      dbg_chk("mis_store.dbg", 8'd2, 64'h88776655BEEF2211);
      do_req("mis_load",  1'b0, 11'h014, 2'd3, 1'b0, 64'h0);
      do_req("mis_half",  1'b1, 11'h011, 2'd1, 1'b0, 64'h0000000000001234);
      dbg_chk("mis_half.dbg", 8'd2, 64'h88776655BEEF2211);

      // 5. Back-to-back store then load of the same byte
      do_req("b2b_store", 1'b1, 11'h020, 2'd0, 1'b0, 64'h000000000000005A);
      do_req("b2b_load",  1'b0, 11'h020, 2'd0, 1'b0, 64'h0);
      do_req("b2b_ldtop", 1'b1, 11'h027, 2'd0, 1'b0, 64'h00000000000000C3);
      do_req("b2b_rddw",  1'b0, 11'h020, 2'd3, 1'b0, 64'h0);
      dbg_chk("b2b.dbg", 8'd4, 64'hC30000000000005A);

      // 6. Reset in the same cycle as a store
      do_req("w6_store",  1'b1, 11'h030, 2'd3, 1'b0, 64'h0102030405060708);
      rst        = 1'b1;
      req_valid  = 1'b1;
      req_write  = 1'b1;
      req_addr   = 11'h030;
      req_size   = 2'd0;
      req_wdata  = 64'h00000000000000FF;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      chk("rst6.valid", {63'h0, resp_valid}, 64'd0);
      chk("rst6.ready", {63'h0, req_ready}, 64'd0);
      dbg_chk("rst6.nowrite", 8'd6, 64'h0102030405060708);
      exp_q.delete();
      model_clear();
      @(posedge clk);
      #1;
      rst = 1'b0;
      wait_clear("clear2");
      dbg_chk("clear2.dbg6", 8'd6, 64'h0);
      dbg_chk("clear2.dbg2", 8'd2, 64'h0);
      do_req("post_ld",   1'b0, 11'h010, 2'd3, 1'b0, 64'h0);
      do_idle("idle2");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
